mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter for the native PicoRV32 memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares one memory/peripheral port between two requesters, for example two cores, or a core and a DMA engine. Arbitration is round-robin with exactly one outstanding transaction. A watchdog completes any transaction the slave never acknowledges, so a dead peripheral address cannot hang a core.

Parameters:
ADDR_WIDTH, 32, width of master and slave address buses
DATA_WIDTH, 32, width of data buses; wstrb width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, slave-wait cycles before forced completion; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_valid  in  1  master 0 request
m0_instr  in  1  master 0 instruction-fetch flag
m0_addr  in  ADDR_WIDTH  master 0 address
m0_wdata  in  DATA_WIDTH  master 0 write data
m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes; 0 means read
m0_ready  out  1  master 0 completion, one-cycle pulse
m0_rdata  out  DATA_WIDTH  master 0 read data, valid while m0_ready=1
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0, for master 1
s_valid  out  1  slave request
s_instr  out  1  slave instruction flag
s_addr  out  ADDR_WIDTH  slave address
s_wdata  out  DATA_WIDTH  slave write data
s_wstrb  out  DATA_WIDTH/8  slave byte strobes
s_ready  in  1  slave completion
s_rdata  in  DATA_WIDTH  slave read data, valid with s_ready
grant_id  out  1  master currently owning the slave; meaningful when busy=1
busy  out  1  a transaction is in flight
timeout_err  out  1  sticky flag: a watchdog timeout has occurred

Behaviour:
- Reset values (asynchronous, immediate on reset=1): all m*_ready, s_valid, busy and timeout_err = 0. s_addr, s_wdata, s_wstrb, s_instr, m*_rdata and grant_id = 0. State = IDLE. last_grant = 1, so master 0 wins the first tie.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one m*_valid is high, grant that master.
  - If both are high, grant the master != last_grant.
  - On grant, register the winner's addr/wdata/wstrb/instr into the s_* outputs, set grant_id and last_grant, clear the watchdog counter, and go to BUSY.
  - No grant is made in the same cycle a response is delivered.
- BUSY:
  - s_valid=1 and busy=1. s_* stay stable until completion.
  - When s_ready=1 is sampled: latch s_rdata into the granted master's m*_rdata, drop s_valid, go to RESP.
  - Otherwise increment the watchdog. If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES: latch ERR_DATA into m*_rdata, set timeout_err, drop s_valid, go to RESP.
- RESP:
  - The granted master's m*_ready=1 for exactly this one cycle, with m*_rdata valid. busy stays 1. Next state is IDLE.
  - The non-granted master's ready is always 0.
- Latency: if the slave acknowledges in its first BUSY cycle, ready is high 2 cycles after valid is first sampled (edge k grant, edge k+1 s_ready sampled, RESP cycle). Minimum bus occupancy is 3 cycles per transaction, including the IDLE turnaround.
- Writes complete identically. m*_rdata is the s_rdata captured at completion, or ERR_DATA on timeout; masters ignore it on writes.
- A granted master dropping valid mid-transaction is illegal. The arbiter still completes the slave transaction and pulses ready.
- A master not granted keeps valid high and waits. Round-robin guarantees service within one transaction of the other master.
- An s_ready arriving in IDLE or RESP is ignored.
- timeout_err clears only on reset.
- Reset mid-transaction aborts immediately: s_valid=0 and no ready pulse is issued.
- The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it cannot wrap.

Decomposition:
- Shared package mem_bus_pkg: FSM state encoding, ERR_DATA default, and a request struct/bundle width constant (addr+wdata+wstrb+instr).
- One natural sub-module: rr_arbiter2 (combinational two-way round-robin pick from the valid bits and last_grant). Watchdog and datapath muxing stay in the top.

Test Plan:
- Single read: m0 read addr 0x0000_0010, slave s_ready on its first valid cycle with rdata 0x1234_5678 → s_addr=0x10 one cycle after m0_valid; m0_ready pulses 1 cycle with m0_rdata=0x1234_5678; m1_ready stays 0.
- Simultaneous requests from reset: m0 read 0x100 and m1 write 0x1000_0000 with wdata 0x41, wstrb 4'b0001 → m0 served first, m1 second with s_wstrb=0001 and s_wdata=0x41. A third back-to-back m0 and m1 pair → m0 then m1 again, strict alternation.
- Slave wait states: s_ready delayed 5 cycles → s_* stable across all 5 cycles, ready delivered in the cycle after s_ready, no second s_valid.
- Timeout: TIMEOUT_CYCLES=8, slave never acknowledges → after 8 BUSY cycles m1_rdata=0xDEAD_BEEF with m1_ready pulse; timeout_err=1 and stays 1 through later good transactions.
- Reset mid-BUSY: assert reset 2 cycles into BUSY → s_valid, busy and ready drop immediately. After release, m0 wins a tie (last_grant reset to 1).
- Watchdog disabled: TIMEOUT_CYCLES=0, s_ready after 1000 cycles → normal completion, timeout_err=0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master PicoRV32 memory bus arbiter:
// FSM encoding, timeout read data and request bundle sizing.
package mem_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_e;

    // Packed request is {instr, addr, wdata, wstrb}.
    function automatic int req_width(input int addr_width, input int data_width);
        return addr_width + data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native PicoRV32 memory bus (valid/ready/addr/wdata/wstrb/rdata) bundle.
// "master" issues requests, "slave" answers them.
interface mem_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      valid;
    logic                      instr;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the master that did not
// win last time is chosen.
module rr_arbiter2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = (last_grant == MASTER_0) ? MASTER_1 : MASTER_0;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter with a single outstanding
// transaction and a watchdog that force-completes unacknowledged accesses.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic      clk,
    input  logic      reset,
    mem_bus_if.slave  m0,
    mem_bus_if.slave  m1,
    mem_bus_if.master s,
    output logic      grant_id,
    output logic      busy,
    output logic      timeout_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int REQ_W  = req_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int WD_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [REQ_W-1:0]      req_q, req_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [REQ_W-1:0]      m0_req, m1_req;
    logic [WD_W-1:0]       wd_inc;
    logic                  pick_valid, pick_id;

    assign m0_req = {m0.instr, m0.addr, m0.wdata, m0.wstrb};
    assign m1_req = {m1.instr, m1.addr, m1.wdata, m1.wstrb};

    rr_arbiter2 u_rr (
        .req        ({m1.valid, m0.valid}),
        .last_grant (last_grant_q),
        .gnt_valid  (pick_valid),
        .gnt_id     (pick_id)
    );

    // Saturating so a disabled or very slow watchdog can never wrap.
    assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        req_d         = req_q;
        wd_d          = wd_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_id;
                    last_grant_d = pick_id;
                    req_d        = (pick_id == MASTER_1) ? m1_req : m0_req;
                    wd_d         = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s.ready) begin
                    if (grant_q == MASTER_1) m1_rdata_d = s.rdata;
                    else                     m0_rdata_d = s.rdata;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_inc;
                    if ((TIMEOUT_CYCLES != 0) && (wd_inc >= WD_LIMIT)) begin
                        if (grant_q == MASTER_1) m1_rdata_d = ERR_DATA;
                        else                     m0_rdata_d = ERR_DATA;
                        timeout_err_d = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= MASTER_0;
            last_grant_q  <= MASTER_1;
            req_q         <= '0;
            wd_q          <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            req_q         <= req_d;
            wd_q          <= wd_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign s.valid = (state_q == ST_BUSY);
    assign s.instr = req_q[REQ_W-1];
    assign s.addr  = req_q[REQ_W-2 -: ADDR_WIDTH];
    assign s.wdata = req_q[DATA_WIDTH+STRB_W-1 -: DATA_WIDTH];
    assign s.wstrb = req_q[STRB_W-1:0];

    assign m0.ready = (state_q == ST_RESP) && (grant_q == MASTER_0);
    assign m1.ready = (state_q == ST_RESP) && (grant_q == MASTER_1);
    assign m0.rdata = m0_rdata_q;
    assign m1.rdata = m1_rdata_q;

    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with an 8-cycle watchdog,
// one with the watchdog disabled.
module tb_mem_bus_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   bad         = 0;

    logic a_grant, a_busy, a_terr;
    logic b_grant, b_busy, b_terr;

    always #5 clk = ~clk;

    mem_bus_if a_m0 ();
    mem_bus_if a_m1 ();
    mem_bus_if a_s  ();
    mem_bus_if b_m0 ();
    mem_bus_if b_m1 ();
    mem_bus_if b_s  ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .m0          (a_m0),
        .m1          (a_m1),
        .s           (a_s),
        .grant_id    (a_grant),
        .busy        (a_busy),
        .timeout_err (a_terr)
    );

    mem_bus_arbiter #(.TIMEOUT_CYCLES(0)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .m0          (b_m0),
        .m1          (b_m1),
        .s           (b_s),
        .grant_id    (b_grant),
        .busy        (b_busy),
        .timeout_err (b_terr)
    );

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic driveM0(input logic v, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        a_m0.valid = v;
        a_m0.instr = 1'b0;
        a_m0.addr  = addr;
        a_m0.wdata = wdata;
        a_m0.wstrb = wstrb;
    endtask

    task automatic driveM1(input logic v, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        a_m1.valid = v;
        a_m1.instr = 1'b0;
        a_m1.addr  = addr;
        a_m1.wdata = wdata;
        a_m1.wstrb = wstrb;
    endtask

    task automatic slaveRespond(input logic rdy, input logic [31:0] data);
        a_s.ready = rdy;
        a_s.rdata = data;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        driveM1(1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 32'h0);
        b_m0.valid = 1'b0; b_m0.instr = 1'b0; b_m0.addr = '0; b_m0.wdata = '0; b_m0.wstrb = '0;
        b_m1.valid = 1'b0; b_m1.instr = 1'b0; b_m1.addr = '0; b_m1.wdata = '0; b_m1.wstrb = '0;
        b_s.ready  = 1'b0; b_s.rdata  = '0;

        applyStimulus(2);
        checkBit("rst_s_valid", a_s.valid, 1'b0);
        checkBit("rst_busy", a_busy, 1'b0);
        checkBit("rst_m0_ready", a_m0.ready, 1'b0);
        checkBit("rst_m1_ready", a_m1.ready, 1'b0);
        checkBit("rst_terr", a_terr, 1'b0);
        checkBit("rst_grant", a_grant, 1'b0);
        checkOutput("rst_s_addr", a_s.addr, 32'h0);
        checkOutput("rst_m0_rdata", a_m0.rdata, 32'h0);
        reset = 1'b0;
        applyStimulus(1);

        $display("[TB] single read");
        driveM0(1'b1, 32'h0000_0010, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("rd_s_valid", a_s.valid, 1'b1);
        checkOutput("rd_s_addr", a_s.addr, 32'h0000_0010);
        checkBit("rd_busy", a_busy, 1'b1);
        checkBit("rd_m0_ready_early", a_m0.ready, 1'b0);
        slaveRespond(1'b1, 32'h1234_5678);
        applyStimulus(1);
        checkBit("rd_m0_ready", a_m0.ready, 1'b1);
        checkOutput("rd_m0_rdata", a_m0.rdata, 32'h1234_5678);
        checkBit("rd_m1_ready", a_m1.ready, 1'b0);
        checkBit("rd_s_valid_drop", a_s.valid, 1'b0);
        checkBit("rd_busy_resp", a_busy, 1'b1);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("rd_m0_ready_once", a_m0.ready, 1'b0);
        checkBit("rd_idle", a_busy, 1'b0);

        $display("[TB] simultaneous requests");
        pulseReset();
        driveM0(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        driveM1(1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001);
        applyStimulus(1);
        checkBit("tie_grant0", a_grant, 1'b0);
        checkOutput("tie_addr0", a_s.addr, 32'h0000_0100);
        checkOutput("tie_wstrb0", 32'(a_s.wstrb), 32'h0);
        slaveRespond(1'b1, 32'hA0A0_0001);
        applyStimulus(1);
        checkBit("tie_m0_ready", a_m0.ready, 1'b1);
        checkBit("tie_m1_wait", a_m1.ready, 1'b0);
        checkOutput("tie_m0_rdata", a_m0.rdata, 32'hA0A0_0001);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("tie_turnaround", a_s.valid, 1'b0);
        applyStimulus(1);
        checkBit("tie_grant1", a_grant, 1'b1);
        checkOutput("tie_addr1", a_s.addr, 32'h1000_0000);
        checkOutput("tie_wdata1", a_s.wdata, 32'h0000_0041);
        checkOutput("tie_wstrb1", 32'(a_s.wstrb), 32'h1);
        slaveRespond(1'b1, 32'h0);
        applyStimulus(1);
        checkBit("tie_m1_ready", a_m1.ready, 1'b1);
        checkBit("tie_m0_quiet", a_m0.ready, 1'b0);
        slaveRespond(1'b0, 32'h0);
        driveM1(1'b0, 32'h0, 32'h0, 4'h0);
        driveM0(1'b1, 32'h0000_0104, 32'h0, 4'h0);
        driveM1(1'b1, 32'h1000_0004, 32'h0000_0042, 4'b0010);
        applyStimulus(2);
        checkBit("alt_grant0", a_grant, 1'b0);
        checkOutput("alt_addr0", a_s.addr, 32'h0000_0104);
        slaveRespond(1'b1, 32'h0000_0007);
        applyStimulus(1);
        checkBit("alt_m0_ready", a_m0.ready, 1'b1);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(2);
        checkBit("alt_grant1", a_grant, 1'b1);
        checkOutput("alt_wstrb1", 32'(a_s.wstrb), 32'h2);
        slaveRespond(1'b1, 32'h0);
        applyStimulus(1);
        checkBit("alt_m1_ready", a_m1.ready, 1'b1);
        slaveRespond(1'b0, 32'h0);
        driveM1(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);

        $display("[TB] slave wait states");
        driveM0(1'b1, 32'h0000_0200, 32'h0, 4'h0);
        applyStimulus(1);
        checkOutput("ws_addr", a_s.addr, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkBit("ws_s_valid", a_s.valid, 1'b1);
            checkOutput("ws_addr_stable", a_s.addr, 32'h0000_0200);
            checkBit("ws_no_ready", a_m0.ready, 1'b0);
        end
        slaveRespond(1'b1, 32'hCAFE_F00D);
        applyStimulus(1);
        checkBit("ws_m0_ready", a_m0.ready, 1'b1);
        checkOutput("ws_m0_rdata", a_m0.rdata, 32'hCAFE_F00D);
        checkBit("ws_s_valid_drop", a_s.valid, 1'b0);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("ws_no_second_valid", a_s.valid, 1'b0);
        checkBit("ws_idle", a_busy, 1'b0);

        $display("[TB] watchdog timeout");
        driveM1(1'b1, 32'h3000_0000, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("to_grant", a_grant, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1);
            checkBit("to_wait_valid", a_s.valid, 1'b1);
            checkBit("to_wait_ready", a_m1.ready, 1'b0);
        end
        checkBit("to_err_before", a_terr, 1'b0);
        applyStimulus(1);
        checkBit("to_m1_ready", a_m1.ready, 1'b1);
        checkOutput("to_m1_rdata", a_m1.rdata, 32'hDEAD_BEEF);
        checkBit("to_err_set", a_terr, 1'b1);
        checkBit("to_s_valid_drop", a_s.valid, 1'b0);
        driveM1(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);
        driveM0(1'b1, 32'h0000_0300, 32'h0, 4'h0);
        applyStimulus(1);
        slaveRespond(1'b1, 32'h0000_5555);
        applyStimulus(1);
        checkBit("to_good_ready", a_m0.ready, 1'b1);
        checkOutput("to_good_rdata", a_m0.rdata, 32'h0000_5555);
        checkBit("to_err_sticky", a_terr, 1'b1);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);

        $display("[TB] reset mid-transaction");
        driveM1(1'b1, 32'h2000_0000, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("rb_grant1", a_grant, 1'b1);
        applyStimulus(2);
        checkBit("rb_busy_before", a_busy, 1'b1);
        reset = 1'b1;
        #1;
        checkBit("rb_s_valid", a_s.valid, 1'b0);
        checkBit("rb_busy", a_busy, 1'b0);
        checkBit("rb_m1_ready", a_m1.ready, 1'b0);
        checkBit("rb_terr_clear", a_terr, 1'b0);
        driveM0(1'b1, 32'h0000_0400, 32'h0, 4'h0);
        applyStimulus(1);
        checkBit("rb_hold_idle", a_s.valid, 1'b0);
        reset = 1'b0;
        applyStimulus(1);
        checkBit("rb_tie_m0", a_grant, 1'b0);
        checkOutput("rb_tie_addr", a_s.addr, 32'h0000_0400);
        slaveRespond(1'b1, 32'h0000_0001);
        applyStimulus(1);
        checkBit("rb_m0_ready", a_m0.ready, 1'b1);
        checkBit("rb_m1_no_ready", a_m1.ready, 1'b0);
        slaveRespond(1'b0, 32'h0);
        driveM0(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(2);
        checkBit("rb_m1_served", a_grant, 1'b1);
        checkOutput("rb_m1_addr", a_s.addr, 32'h2000_0000);
        slaveRespond(1'b1, 32'h0000_0002);
        applyStimulus(1);
        checkBit("rb_m1_ready2", a_m1.ready, 1'b1);
        checkOutput("rb_m1_rdata", a_m1.rdata, 32'h0000_0002);
        slaveRespond(1'b0, 32'h0);
        driveM1(1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1);

        $display("[TB] watchdog disabled");
        b_m0.valid = 1'b1;
        b_m0.addr  = 32'h0000_0040;
        applyStimulus(1);
        checkBit("nd_s_valid", b_s.valid, 1'b1);
        for (int i = 0; i < 999; i++) begin
            applyStimulus(1);
            if (!b_s.valid || b_m0.ready) bad++;
        end
        checkOutput("nd_wait_stable", 32'(bad), 32'h0);
        b_s.ready = 1'b1;
        b_s.rdata = 32'h600D_0001;
        applyStimulus(1);
        checkBit("nd_m0_ready", b_m0.ready, 1'b1);
        checkOutput("nd_m0_rdata", b_m0.rdata, 32'h600D_0001);
        checkBit("nd_terr", b_terr, 1'b0);
        b_s.ready  = 1'b0;
        b_m0.valid = 1'b0;
        applyStimulus(1);
        checkBit("nd_idle", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
